// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: cell functions and cell-kind type shared by the approximate adder
package approx_adder_pkg;

    typedef enum logic {CELL_EXACT, CELL_APPROX} cell_kind_e;

    // Approximate cell: carry is simply X, sum depends on X selecting AND or OR of Y,Z
    function automatic logic [1:0] approx_fa(input logic x, input logic y, input logic z);
        return {x, x ? (y & z) : (y | z)};
    endfunction

    function automatic logic [1:0] exact_fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage

// File: rtl/approx_adder_seg.sv
// approx_adder_seg: combinational SEG_W-bit ripple segment mixing approximate and exact cells
module approx_adder_seg
    import approx_adder_pkg::*;
#(
    parameter int SEG_W       = 8,
    parameter int BASE_BIT    = 0,
    parameter int APPROX_BITS = 7
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             approx,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    cell_kind_e kind;
    logic       c;
    logic [1:0] r;

    // Ripple through the segment, picking the cell kind by absolute bit position
    always_comb begin
        c    = cin;
        s    = '0;
        kind = CELL_EXACT;
        r    = '0;
        for (int i = 0; i < SEG_W; i++) begin
            kind = (approx && (BASE_BIT + i < APPROX_BITS)) ? CELL_APPROX : CELL_EXACT;
            r    = (kind == CELL_APPROX) ? approx_fa(a[i], b[i], c) : exact_fa(a[i], b[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        cout = c;
    end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// approx_rc_adder_pipe: pipelined approximate ripple-carry adder; ERR_MONITOR_EN adds an error monitor
module approx_rc_adder_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 7,
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
`ifdef ERR_MONITOR_EN
    ,
    input  logic             mon_clr,
    output logic [CNT_W-1:0] mon_count,
    output logic [WIDTH:0]   mon_maxerr
`endif
);

    localparam int SEG_W = WIDTH / STAGES;

    typedef struct packed {
        logic             v;
        logic             ap;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
`ifdef ERR_MONITOR_EN
        logic [WIDTH:0]   ex;
`endif
    } stage_t;

    stage_t           st  [STAGES];
    stage_t           src [STAGES];
    stage_t           nx  [STAGES];
    logic [WIDTH-1:0] seg_s;
    logic [STAGES-1:0] seg_c;
    logic             adv;

    assign adv       = !st[STAGES-1].v || out_ready;
    assign in_ready  = adv;
    assign out_valid = st[STAGES-1].v;
    assign out_sum   = {st[STAGES-1].c, st[STAGES-1].s};

    // Each segment works on the incoming operands or on the previous stage's registered state
    always_comb begin
        src[0]    = '0;
        src[0].v  = in_valid;
        src[0].ap = in_approx;
        src[0].a  = in_a;
        src[0].b  = in_b;
`ifdef ERR_MONITOR_EN
        src[0].ex = {1'b0, in_a} + {1'b0, in_b};
`endif
        for (int k = 1; k < STAGES; k++) src[k] = st[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        approx_adder_seg #(
            .SEG_W      (SEG_W),
            .BASE_BIT   (k * SEG_W),
            .APPROX_BITS(APPROX_BITS)
        ) u_seg (
            .a     (src[k].a[k*SEG_W +: SEG_W]),
            .b     (src[k].b[k*SEG_W +: SEG_W]),
            .approx(src[k].ap),
            .cin   (src[k].c),
            .s     (seg_s[k*SEG_W +: SEG_W]),
            .cout  (seg_c[k])
        );
    end

    // Merge each segment's partial sum and carry into the state it forwards
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx[k]                      = src[k];
            nx[k].s[k*SEG_W +: SEG_W]  = seg_s[k*SEG_W +: SEG_W];
            nx[k].c                    = seg_c[k];
        end
    end

    // All stages advance together on the global enable and freeze under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) st[k] <= nx[k];
        end
    end

`ifdef ERR_MONITOR_EN
    logic [WIDTH:0] ex_q;
    logic [WIDTH:0] diff;

    assign ex_q = st[STAGES-1].ex;
    assign diff = (out_sum > ex_q) ? out_sum - ex_q : ex_q - out_sum;

    // Count mismatching results and track the worst absolute error on each output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_count  <= '0;
            mon_maxerr <= '0;
        end else if (mon_clr) begin
            mon_count  <= '0;
            mon_maxerr <= '0;
        end else if (out_valid && out_ready && out_sum != ex_q) begin
            mon_count  <= (&mon_count) ? mon_count : mon_count + 1'b1;
            mon_maxerr <= (diff > mon_maxerr) ? diff : mon_maxerr;
        end
    end
`endif

endmodule
